dmem_wait_ctrl: RTL and testbench

- Parametrised data-memory subsystem for the pipelined RISC-V core; replaces the single-cycle data memory behind the MEM stage.
- Adds a request/ready handshake with a configurable number of wait states, so the hazard unit can stall on slow memory.
- Handles RV32I byte, halfword and word loads and stores from funct3, with sign or zero extension.
- Reports misaligned, out-of-range and illegal accesses.

---
 rtl/dmem_wait_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_ctrl.sv
// Data memory for the MEM stage with a req/ready handshake and WAIT_CYCLES wait states.
// Supports RV32I byte/half/word loads and stores, and flags misaligned, out-of-range and illegal accesses.
module dmem_wait_ctrl #(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  funct3,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] rd_q;
    logic        ready_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    function automatic logic access_fault(input logic [31:0] addr, input logic is_st,
                                          input logic [2:0] f3);
        logic bad_f3;
        logic misal;
        logic oor;
        if (is_st) bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
        else       bad_f3 = (f3 inside {3'b011, 3'b110, 3'b111});
        misal = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        oor   = |addr[31:AW+2];
        return bad_f3 | misal | oor;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // In IDLE the response (zero wait states) is built from the live inputs, later from the latched copies.
    logic        idle;
    logic [31:0] op_a;
    logic        op_we;
    logic [2:0]  op_f3;
    logic        op_fault;
    logic [31:0] op_rd;

    assign idle     = (state_q == IDLE);
    assign op_a     = idle ? a      : a_q;
    assign op_we    = idle ? we     : we_q;
    assign op_f3    = idle ? funct3 : f3_q;
    assign op_fault = access_fault(op_a, op_we, op_f3);
    assign op_rd    = (op_fault || op_we) ? 32'h0
                    : load_extend(mem[op_a[AW+1:2]], op_a[1:0], op_f3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= op_fault;
                            rd_q    <= op_rd;
                        end else begin
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= op_fault;
                        rd_q    <= op_rd;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (idle && req) begin
            a_q  <= a;
            we_q <= we;
            wd_q <= wd;
            f3_q <= funct3;
        end
    end

    // Store commits on the edge that ends RESP; reset at that edge abandons it.
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    assign wr_be   = store_be(a_q[1:0], f3_q);
    assign wr_data = store_data(wd_q, f3_q);

    always_ff @(posedge clk) begin
        if (reset && (state_q == RESP) && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[a_q[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign stall = req & ~ready_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: table of accesses on a WAIT_CYCLES=1 instance, scoreboarded responses,
// plus latency, reset-abandon and back-to-back sequences on instances with 1, 3 and 0 wait states.
module tb_dmem_wait_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        req_v   [3];
    logic [31:0] rd_v    [3];
    logic        ready_v [3];
    logic        err_v   [3];
    logic        stall_v [3];

    dmem_wait_ctrl #(.DEPTH(256), .WAIT_CYCLES(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .reset(rst_n), .req(req_v[0]), .we(we), .a(a), .wd(wd), .funct3(f3),
        .rd(rd_v[0]), .ready(ready_v[0]), .err(err_v[0]), .stall(stall_v[0]));
    dmem_wait_ctrl #(.DEPTH(256), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
        .clk(clk), .reset(rst_n), .req(req_v[1]), .we(we), .a(a), .wd(wd), .funct3(f3),
        .rd(rd_v[1]), .ready(ready_v[1]), .err(err_v[1]), .stall(stall_v[1]));
    dmem_wait_ctrl #(.DEPTH(256), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(rst_n), .req(req_v[2]), .we(we), .a(a), .wd(wd), .funct3(f3),
        .rd(rd_v[2]), .ready(ready_v[2]), .err(err_v[2]), .stall(stall_v[2]));

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q [3][$];
    vec_t tbl [$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] ad, input logic [31:0] d,
                                input logic [2:0] f, input logic e, input logic [31:0] r);
        vec_t v;
        v.we = w; v.a = ad; v.wd = d; v.f3 = f; v.err = e; v.rd = r;
        return v;
    endfunction

    task automatic push_exp(input int k, input vec_t v);
        exp_t e;
        e.chk_rd = !v.we || v.err;
        e.rd     = v.rd;
        e.err    = v.err;
        exp_q[k].push_back(e);
    endtask

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ready_v[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready[%0d]: got ready=1, required no response", k);
                end else begin
                    e = exp_q[k].pop_front();
                    check1($sformatf("err[%0d] a=%08h", k, a), err_v[k], e.err);
                    if (e.chk_rd) check32($sformatf("rd[%0d] a=%08h", k, a), rd_v[k], e.rd);
                end
            end
        end
    end

    task automatic access(input int k, input vec_t v, input int wc);
        int lat;
        @(negedge clk);
        we = v.we; a = v.a; wd = v.wd; f3 = v.f3; req_v[k] = 1'b1;
        push_exp(k, v);
        #1 check1($sformatf("stall_c0[%0d]", k), stall_v[k], 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (ready_v[k] !== 1'b1 && lat <= wc)
                check1($sformatf("stall_wait[%0d]", k), stall_v[k], 1'b1);
        end while (ready_v[k] !== 1'b1 && lat < 40);
        check32($sformatf("latency[%0d] a=%08h", k, v.a), 32'(lat), 32'(wc + 1));
        check1($sformatf("stall_resp[%0d]", k), stall_v[k], 1'b0);
        req_v[k] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int t, first, second;
        rst_n = 1'b0;
        we = 1'b0; a = '0; wd = '0; f3 = '0;
        for (int k = 0; k < 3; k++) req_v[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check1($sformatf("rst_ready[%0d]", k), ready_v[k], 1'b0);
            check1($sformatf("rst_err[%0d]", k), err_v[k], 1'b0);
            check32($sformatf("rst_rd[%0d]", k), rd_v[k], 32'h0);
            check1($sformatf("rst_stall[%0d]", k), stall_v[k], 1'b0);
        end
        rst_n = 1'b1;

        tbl.push_back(mk(1, 32'h010, 32'hDEADBEEF, W,  0, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,        W,  0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 32'h011, 32'h00000080, B,  0, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,        W,  0, 32'hDEAD80EF));
        tbl.push_back(mk(0, 32'h011, 32'h0,        B,  0, 32'hFFFFFF80));
        tbl.push_back(mk(0, 32'h011, 32'h0,        BU, 0, 32'h00000080));
        tbl.push_back(mk(0, 32'h012, 32'h0,        H,  0, 32'hFFFFDEAD));
        tbl.push_back(mk(0, 32'h012, 32'h0,        HU, 0, 32'h0000DEAD));
        tbl.push_back(mk(0, 32'h010, 32'h0,        B,  0, 32'hFFFFFFEF));
        tbl.push_back(mk(0, 32'h013, 32'h0,        BU, 0, 32'h000000DE));
        tbl.push_back(mk(1, 32'h013, 32'h0000FFFF, H,  1, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,        W,  0, 32'hDEAD80EF));
        tbl.push_back(mk(0, 32'h402, 32'h0,        W,  1, 32'h0));
        tbl.push_back(mk(0, 32'h400, 32'h0,        W,  1, 32'h0));
        tbl.push_back(mk(0, 32'h011, 32'h0,        H,  1, 32'h0));
        tbl.push_back(mk(0, 32'h012, 32'h0,        W,  1, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,   3'b011,  1, 32'h0));
        tbl.push_back(mk(1, 32'h010, 32'h0,   3'b100,  1, 32'h0));
        tbl.push_back(mk(1, 32'h010, 32'h0,   3'b011,  1, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,   3'b110,  1, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,        W,  0, 32'hDEAD80EF));
        tbl.push_back(mk(1, 32'h014, 32'h00000000, W,  0, 32'h0));
        tbl.push_back(mk(1, 32'h016, 32'h1234ABCD, H,  0, 32'h0));
        tbl.push_back(mk(0, 32'h014, 32'h0,        W,  0, 32'hABCD0000));
        tbl.push_back(mk(0, 32'h017, 32'h0,        B,  0, 32'hFFFFFFAB));
        tbl.push_back(mk(0, 32'h014, 32'h0,        HU, 0, 32'h00000000));
        tbl.push_back(mk(1, 32'h013, 32'h0000007F, B,  0, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,        W,  0, 32'h7FAD80EF));
        tbl.push_back(mk(1, 32'h3FC, 32'hA5A55A5A, W,  0, 32'h0));
        tbl.push_back(mk(0, 32'h3FC, 32'h0,        W,  0, 32'hA5A55A5A));
        tbl.push_back(mk(1, 32'h010, 32'h00008001, H,  0, 32'h0));
        tbl.push_back(mk(0, 32'h010, 32'h0,        H,  0, 32'hFFFF8001));
        tbl.push_back(mk(0, 32'h010, 32'h0,        W,  0, 32'h7FAD8001));
        tbl.push_back(mk(1, 32'h000, 32'h55555555, W,  0, 32'h0));
        tbl.push_back(mk(1, 32'h400, 32'hBADBAD00, W,  1, 32'h0));
        tbl.push_back(mk(0, 32'h000, 32'h0,        W,  0, 32'h55555555));
        tbl.push_back(mk(1, 32'h020, 32'h11111111, W,  0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) access(0, tbl[i], 1);

        // Back-to-back loads with req held high: second ready three cycles after the first.
        push_exp(0, mk(0, 32'h010, 32'h0, W, 0, 32'h7FAD8001));
        push_exp(0, mk(0, 32'h014, 32'h0, W, 0, 32'hABCD0000));
        @(negedge clk);
        we = 1'b0; a = 32'h010; f3 = W; req_v[0] = 1'b1;
        t = 0; first = -1; second = -1;
        while (second < 0 && t < 40) begin
            @(negedge clk);
            t++;
            if (ready_v[0] === 1'b1) begin
                if (first < 0) begin
                    first = t;
                    a = 32'h014;
                end else begin
                    second = t;
                end
            end else if (first >= 0 && t == first + 1) begin
                check1("b2b_stall_idle", stall_v[0], 1'b1);
            end
        end
        req_v[0] = 1'b0;
        check32("b2b_first_latency", 32'(first), 32'd2);
        check32("b2b_second_latency", 32'(second), 32'd5);

        // Reset during WAIT abandons the store; reset also dominates a held request.
        @(negedge clk);
        we = 1'b1; a = 32'h020; wd = 32'h12345678; f3 = W; req_v[0] = 1'b1;
        @(negedge clk);
        check1("abandon_wait_ready", ready_v[0], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check1("abandon_rst_ready", ready_v[0], 1'b0);
        check1("abandon_rst_err", err_v[0], 1'b0);
        check32("abandon_rst_rd", rd_v[0], 32'h0);
        @(negedge clk);
        check1("rst_dominates_req", ready_v[0], 1'b0);
        rst_n = 1'b1;
        req_v[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check1("no_resp_after_reset", ready_v[0], 1'b0);
        end
        access(0, mk(0, 32'h020, 32'h0, W, 0, 32'h11111111), 1);

        // Latency with three and with zero wait states.
        access(1, mk(1, 32'h010, 32'hCAFEF00D, W, 0, 32'h0), 3);
        access(1, mk(0, 32'h010, 32'h0,        W, 0, 32'hCAFEF00D), 3);
        access(1, mk(0, 32'h011, 32'h0,        W, 1, 32'h0), 3);
        access(2, mk(1, 32'h008, 32'h01234567, W, 0, 32'h0), 0);
        access(2, mk(0, 32'h00A, 32'h0,        H, 0, 32'h00000123), 0);
        access(2, mk(0, 32'h008, 32'h0,        B, 0, 32'h00000067), 0);
        access(2, mk(1, 32'h009, 32'h0,        H, 1, 32'h0), 0);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check32($sformatf("pending_responses[%0d]", k), 32'(exp_q[k].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
